// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: ID/EX operand fields and instruction class in,
// stall/bubble/flush controls, MDU handshake and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_reg_wr;
  logic             ex_is_load;
  logic             ex_is_mdu;
  logic             ex_branch_taken;
  logic             mdu_done;
  logic             mdu_start;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             bubble_ex;
  logic             flush_id;
  logic             flush_ex;
  logic             mdu_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_wr,
           ex_is_load, ex_is_mdu, ex_branch_taken, mdu_done,
    input  mdu_start, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, flush_ex, mdu_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_wr,
           ex_is_load, ex_is_mdu, ex_branch_taken, mdu_done,
    output mdu_start, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, flush_ex, mdu_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing controller: load-use interlock, MUL/DIV wait
// handshake with timeout, taken-branch flush, saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int WW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MDU_TIMEOUT);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          err_set;
  logic          load_use;
  logic          start, s_if, s_id, s_ex, bub, f_id, f_ex;

  assign load_use = hz.ex_is_load && hz.ex_reg_wr && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    start     = 1'b0;
    s_if      = 1'b0;
    s_id      = 1'b0;
    s_ex      = 1'b0;
    bub       = 1'b0;
    f_id      = 1'b0;
    f_ex      = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_is_mdu) begin
          start     = 1'b1;
          s_if      = 1'b1;
          s_id      = 1'b1;
          s_ex      = 1'b1;
          state_nxt = MDU_WAIT;
          wait_nxt  = WW'(1);
        end else if (hz.ex_branch_taken) begin
          f_id = 1'b1;
          f_ex = 1'b1;
        end else if (load_use) begin
          s_if = 1'b1;
          bub  = 1'b1;
        end
      end
      default: begin
        // Release on done or timeout happens in the same cycle, so EX
        // captures the MDU result (or gives up) at the closing edge.
        if (hz.mdu_done) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == TMO) begin
          err_set   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          s_if     = 1'b1;
          s_id     = 1'b1;
          s_ex     = 1'b1;
          wait_nxt = wait_cnt + 1'b1;
        end
      end
    endcase
  end

  // Decoded controls are forced low while reset is held.
  always_comb begin
    hz.mdu_start = rst_n & start;
    hz.stall_if  = rst_n & s_if;
    hz.stall_id  = rst_n & s_id;
    hz.stall_ex  = rst_n & s_ex;
    hz.bubble_ex = rst_n & bub;
    hz.flush_id  = rst_n & f_id;
    hz.flush_ex  = rst_n & f_ex;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      hz.mdu_err   <= 1'b0;
      hz.stall_cnt <= '0;
      hz.flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set)
        hz.mdu_err <= 1'b1;
      if (s_if && (hz.stall_cnt != '1))
        hz.stall_cnt <= hz.stall_cnt + 1'b1;
      if (f_ex && (hz.flush_cnt != '1))
        hz.flush_cnt <= hz.flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for RUN-state decode plus
// hand-written MDU handshake, timeout, back-to-back, saturation and reset runs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(4))  ha ();
  hazard_ctrl_if #(.CNT_W(16)) hb ();

  hazard_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (ha.slave)
  );

  hazard_ctrl #(.CNT_W(16), .MDU_TIMEOUT(4)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hb.slave)
  );

  assign hb.id_rs1          = ha.id_rs1;
  assign hb.id_rs2          = ha.id_rs2;
  assign hb.id_use_rs1      = ha.id_use_rs1;
  assign hb.id_use_rs2      = ha.id_use_rs2;
  assign hb.ex_rd           = ha.ex_rd;
  assign hb.ex_reg_wr       = ha.ex_reg_wr;
  assign hb.ex_is_load      = ha.ex_is_load;
  assign hb.ex_is_mdu       = ha.ex_is_mdu;
  assign hb.ex_branch_taken = ha.ex_branch_taken;
  assign hb.mdu_done        = ha.mdu_done;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       mdu;
    logic       br;
    logic       done;
    logic [7:0] exp;
  } vec_t;

  // exp bits: {mdu_start, stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex, mdu_err}
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] LUSE  = 8'b0100_1000;
  localparam logic [7:0] FLUSH = 8'b0000_0110;
  localparam logic [7:0] LAUNCH = 8'b1111_0000;
  localparam logic [7:0] WAIT  = 8'b0111_0000;
  localparam logic [7:0] ERR   = 8'b0000_0001;

  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic ld, input logic mdu,
                              input logic br, input logic done, input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.wr = wr; v.ld = ld; v.mdu = mdu; v.br = br; v.done = done; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] out_a();
    return {ha.mdu_start, ha.stall_if, ha.stall_id, ha.stall_ex,
            ha.bubble_ex, ha.flush_id, ha.flush_ex, ha.mdu_err};
  endfunction

  function automatic logic [7:0] out_b();
    return {hb.mdu_start, hb.stall_if, hb.stall_id, hb.stall_ex,
            hb.bubble_ex, hb.flush_id, hb.flush_ex, hb.mdu_err};
  endfunction

  task automatic drive(input vec_t v);
    ha.id_rs1          = v.rs1;
    ha.id_rs2          = v.rs2;
    ha.id_use_rs1      = v.u1;
    ha.id_use_rs2      = v.u2;
    ha.ex_rd           = v.rd;
    ha.ex_reg_wr       = v.wr;
    ha.ex_is_load      = v.ld;
    ha.ex_is_mdu       = v.mdu;
    ha.ex_branch_taken = v.br;
    ha.mdu_done        = v.done;
  endtask

  task automatic cyc(input vec_t v);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Structural invariants checked every cycle on the narrow-counter instance
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(ha.ex_is_mdu && ha.ex_branch_taken))
        else $error("illegal stimulus: mdu with branch");
      if (ha.bubble_ex && ha.stall_id) begin
        miscompares++;
        $display("FAIL inv_bubble_stall: bubble_ex=1 stall_id=1 required not both");
      end
      if ((ha.flush_id || ha.flush_ex) && (ha.stall_if || ha.stall_id || ha.stall_ex)) begin
        miscompares++;
        $display("FAIL inv_flush_stall: flush with stall asserted, required exclusive");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  vec_t idle, mdu, mdu_done, done_only, lu;

  initial begin
    idle      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    mdu       = mk(0, 0, 0, 0, 3, 1, 0, 1, 0, 0, NONE);
    mdu_done  = mk(0, 0, 0, 0, 3, 1, 0, 1, 0, 1, NONE);
    done_only = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    lu        = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, LUSE);

    tbl[0] = mk( 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, NONE);
    tbl[1] = mk( 5,  0, 1, 0,  5, 1, 1, 0, 0, 0, LUSE);
    tbl[2] = mk( 0,  0, 1, 0,  0, 1, 1, 0, 0, 0, NONE);
    tbl[3] = mk( 5,  0, 1, 0,  5, 0, 1, 0, 0, 0, NONE);
    tbl[4] = mk( 1,  7, 1, 1,  7, 1, 1, 0, 0, 0, LUSE);
    tbl[5] = mk( 1,  7, 1, 0,  7, 1, 1, 0, 0, 0, NONE);
    tbl[6] = mk( 5,  5, 1, 1,  5, 1, 0, 0, 0, 0, NONE);
    tbl[7] = mk( 5,  0, 1, 0,  5, 1, 1, 0, 1, 0, FLUSH);
    tbl[8] = mk( 2,  3, 1, 1,  9, 1, 0, 0, 1, 0, FLUSH);
    tbl[9] = mk(31, 31, 1, 1, 31, 1, 1, 0, 0, 0, LUSE);

    // Reset state
    do_reset();
    #1;
    chk("reset_out_a", out_a(), NONE);
    chk("reset_out_b", out_b(), NONE);
    chk_n("reset_stall_cnt", int'(ha.stall_cnt), 0);
    chk_n("reset_flush_cnt", int'(ha.flush_cnt), 0);

    // RUN-state decode table
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i]);
      chk($sformatf("table_%0d", i), out_a(), tbl[i].exp);
    end
    cyc(idle);
    chk("table_idle", out_a(), NONE);
    chk_n("table_stall_cnt", int'(ha.stall_cnt), 3);
    chk_n("table_flush_cnt", int'(ha.flush_cnt), 2);

    // MDU handshake: launch at cycle 0, done at cycle 5
    do_reset();
    cyc(mdu);
    chk("mdu_c0", out_a(), LAUNCH);
    for (int c = 1; c < 5; c++) begin
      cyc(mdu);
      chk($sformatf("mdu_c%0d", c), out_a(), WAIT);
    end
    cyc(mdu_done);
    chk("mdu_c5_done", out_a(), NONE);
    cyc(idle);
    chk("mdu_c6", out_a(), NONE);
    chk_n("mdu_stall_cnt", int'(ha.stall_cnt), 5);

    // MDU timeout on the MDU_TIMEOUT=4 instance
    do_reset();
    cyc(mdu);
    chk("tmo_c0", out_b(), LAUNCH);
    for (int c = 1; c < 4; c++) begin
      cyc(mdu);
      chk($sformatf("tmo_c%0d", c), out_b(), WAIT);
    end
    cyc(mdu);
    chk("tmo_c4_release", out_b(), NONE);
    cyc(idle);
    chk("tmo_c5_err", out_b(), ERR);
    cyc(lu);
    chk("tmo_c6_run_luse", out_b(), LUSE | ERR);
    cyc(idle);
    chk("tmo_c7_sticky", out_b(), ERR);
    chk_n("tmo_stall_cnt", int'(hb.stall_cnt), 5);

    // Back-to-back MDU ops: launches two cycles apart
    do_reset();
    cyc(mdu);
    chk("b2b_c0", out_a(), LAUNCH);
    cyc(mdu_done);
    chk("b2b_c1_done", out_a(), NONE);
    cyc(mdu);
    chk("b2b_c2_relaunch", out_a(), LAUNCH);
    cyc(mdu_done);
    chk("b2b_c3_done", out_a(), NONE);
    cyc(idle);
    chk("b2b_c4", out_a(), NONE);

    // Stall counter saturation at 15 (CNT_W=4)
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(lu);
      chk($sformatf("sat_out_%0d", i), out_a(), LUSE);
      chk_n($sformatf("sat_cnt_%0d", i), int'(ha.stall_cnt), (i < 15) ? i : 15);
    end
    cyc(idle);
    chk_n("sat_final", int'(ha.stall_cnt), 15);

    // Asynchronous reset in the middle of MDU_WAIT
    do_reset();
    cyc(mdu);
    chk("arst_c0", out_a(), LAUNCH);
    cyc(mdu);
    cyc(mdu);
    chk("arst_c2", out_a(), WAIT);
    @(posedge clk);
    #1 drive(mdu);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_during", out_a(), NONE);
    chk_n("arst_stall_cnt", int'(ha.stall_cnt), 0);
    drive(idle);
    #3 rst_n = 1'b1;
    cyc(done_only);
    chk("arst_done_ignored", out_a(), NONE);
    cyc(idle);
    chk("arst_after", out_a(), NONE);
    chk_n("arst_cnt_after", int'(ha.stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
